// File: rtl/fib_capture_fifo.sv
// Captures each new stable value from the slow Fibonacci stage into a Wishbone-read FIFO.
// Define FIB_CAPTURE_TIMESTAMP_EN to add per-entry cycle stamps, readable at offset 0x10.
module fib_capture_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 8
) (
   input  logic             wb_clk_i,
   input  logic             reset,
   input  logic [WIDTH-1:0] value_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [5:0]       wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   output logic             irq_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [5:0] ADR_STATUS = 6'h00;
   localparam logic [5:0] ADR_POP    = 6'h04;
   localparam logic [5:0] ADR_CTRL   = 6'h08;
   localparam logic [5:0] ADR_CMD    = 6'h0C;
   localparam logic [5:0] ADR_STAMP  = 6'h10;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_last;
   logic             r_have_last;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_ovf;
   logic             r_en;
   logic             r_irq_en;
   logic [3:0]       r_thr;
   logic             r_ack;
   logic [31:0]      r_dat;
   logic             r_irq;

   logic             w_req;
   logic             w_rd;
   logic             w_wr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_flush;
   logic             w_clr_ovf;
   logic             w_ctrl_wr;
   logic             w_want;
   logic             w_push;
   logic             w_drop;
   logic [3:0]       w_thr_eff;
   logic             w_irq_next;
   logic [31:0]      w_status;
   logic [31:0]      w_ctrl;
   logic [31:0]      w_rdata;
   logic             w_unused;

   // A new request is only taken while ack is low, so every access acks exactly once.
   assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
   assign w_rd      = w_req & ~wbs_we_i;
   assign w_wr      = w_req & wbs_we_i;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_pop     = w_rd & (wbs_adr_i == ADR_POP) & ~w_empty;
   assign w_flush   = w_wr & (wbs_adr_i == ADR_CMD) & wbs_dat_i[0];
   assign w_clr_ovf = w_wr & (wbs_adr_i == ADR_CMD) & wbs_dat_i[1];
   assign w_ctrl_wr = w_wr & (wbs_adr_i == ADR_CTRL);

   // A dropped value is not recorded as pushed, so it retries while held and lands on the next pop.
   assign w_want    = r_en & (r_s1 == r_s2) & (~r_have_last | (r_s2 != r_last));
   assign w_push    = w_want & (~w_full | w_pop) & ~w_flush;
   assign w_drop    = w_want & w_full & ~w_pop & ~w_flush;

   assign w_thr_eff  = (r_thr == 4'd0) ? 4'd1 : r_thr;
   assign w_irq_next = r_irq_en & ((5'(r_count) >= 5'(w_thr_eff)) | r_ovf);

   assign w_status = {21'b0, r_ovf, w_full, w_empty, 8'(r_count)};
   assign w_ctrl   = {20'b0, r_thr, 6'b0, r_irq_en, r_en};
   assign w_unused = ^{wbs_dat_i[31:12], wbs_dat_i[7:2]};

`ifdef FIB_CAPTURE_TIMESTAMP_EN
   logic [31:0] r_cyc;
   logic [31:0] r_pop_stamp;
   logic [31:0] r_stamp [DEPTH];

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_cyc       <= '0;
         r_pop_stamp <= '0;
      end else begin
         r_cyc <= r_cyc + 32'd1;
         if (w_pop) r_pop_stamp <= r_stamp[r_rd_ptr];
      end
   end

   // Stamp is the count value of the cycle in which the entry becomes visible.
   always_ff @(posedge wb_clk_i) begin
      if (w_push) r_stamp[r_wr_ptr] <= r_cyc + 32'd1;
   end
`endif

   always_comb begin
      w_rdata = '0;
      if (!wbs_we_i) begin
         case (wbs_adr_i)
            ADR_STATUS: w_rdata = w_status;
            ADR_POP:    w_rdata = w_empty ? 32'd0 : 32'(r_mem[r_rd_ptr]);
            ADR_CTRL:   w_rdata = w_ctrl;
`ifdef FIB_CAPTURE_TIMESTAMP_EN
            ADR_STAMP:  w_rdata = r_pop_stamp;
`endif
            default:    w_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= r_s2;
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         r_s1        <= '0;
         r_s2        <= '0;
         r_last      <= '0;
         r_have_last <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_en        <= 1'b1;
         r_irq_en    <= 1'b0;
         r_thr       <= 4'd1;
         r_ack       <= 1'b0;
         r_dat       <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_s1  <= value_i;
         r_s2  <= r_s1;
         r_ack <= w_req;
         r_irq <= w_irq_next;
         if (w_req) r_dat <= w_rdata;

         if (w_ctrl_wr) begin
            r_en     <= wbs_dat_i[0];
            r_irq_en <= wbs_dat_i[1];
            r_thr    <= wbs_dat_i[11:8];
         end

         if (w_drop)         r_ovf <= 1'b1;
         else if (w_clr_ovf) r_ovf <= 1'b0;

         if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_have_last <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr    <= r_wr_ptr + AW'(1);
               r_last      <= r_s2;
               r_have_last <= 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
         end
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign irq_o     = r_irq;

endmodule
